// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forward-select encodings and shadow write-control types.
// Rev 1.0
`default_nettype none

package hazard_pkg;

    // Matches the datapath 3:1 operand mux ordering
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_RESULTW = 2'b01;
    localparam logic [1:0] FWD_ALUOUTM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_fwd_sel.sv
// fwd_sel: execute-stage operand forward select for one source specifier.
// Rev 1.0
`default_nettype none

module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] dst_m,
    input  logic [REG_AW-1:0] dst_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic src_live;
    logic hit_m;
    logic hit_w;

    assign src_live = (src != ZERO);
    assign hit_m    = src_live && reg_write_m && (src == dst_m);
    assign hit_w    = src_live && reg_write_w && (src == dst_w);

    // M holds the newer value, so it wins when both stages match
    always_comb begin
        sel = FWD_REG;
        if (hit_m) begin
            sel = FWD_ALUOUTM;
        end else if (hit_w) begin
            sel = FWD_RESULTW;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control with a shadow write-control pipeline.
// Rev 1.0
`default_nettype none

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteD,
    input  logic              MemToRegD,
    input  logic              BranchD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  br_stall_cnt
);

    localparam logic [REG_AW-1:0] ZERO    = REG_AW'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    wb_ctrl_t ctrl_e;
    wb_ctrl_t ctrl_m;
    wb_ctrl_t ctrl_w;

    logic             lwstall;
    logic             brstall;
    logic             br_dep_e;
    logic             br_dep_m;
    logic             stall;
    logic [CNT_W-1:0] lw_cnt;
    logic [CNT_W-1:0] br_cnt;

    logic [REG_AW-1:0] src_e [2];
    logic [1:0]        sel_e [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e <= '0;
            ctrl_m <= '0;
            ctrl_w <= '0;
        end else begin
            // A flush turns the instruction entering E into a bubble
            ctrl_e.reg_write  <= RegWriteD & ~stall;
            ctrl_e.mem_to_reg <= MemToRegD & ~stall;
            ctrl_m            <= ctrl_e;
            ctrl_w            <= ctrl_m;
        end
    end

    assign RegWriteM = ctrl_m.reg_write;
    assign RegWriteW = ctrl_w.reg_write;
    assign MemToRegW = ctrl_w.mem_to_reg;

    assign lwstall = ctrl_e.mem_to_reg && (RtE != ZERO) && ((RtE == RsD) || (RtE == RtD));

    // Branch compares in D need operands that are still in flight in E or as a load in M
    assign br_dep_e = ctrl_e.reg_write && (WriteRegE != ZERO)
                      && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign br_dep_m = ctrl_m.mem_to_reg && (WriteRegM != ZERO)
                      && ((WriteRegM == RsD) || (WriteRegM == RtD));
    assign brstall  = BranchD && (br_dep_e || br_dep_m);

    assign stall  = lwstall || brstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    assign ForwardAD = (RsD != ZERO) && (RsD == WriteRegM) && ctrl_m.reg_write;
    assign ForwardBD = (RtD != ZERO) && (RtD == WriteRegM) && ctrl_m.reg_write;

    assign src_e[0] = RsE;
    assign src_e[1] = RtE;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_fwd
            fwd_sel #(
                .REG_AW (REG_AW)
            ) u_fwd_sel (
                .src         (src_e[i]),
                .dst_m       (WriteRegM),
                .dst_w       (WriteRegW),
                .reg_write_m (ctrl_m.reg_write),
                .reg_write_w (ctrl_w.reg_write),
                .sel         (sel_e[i])
            );
        end
    endgenerate

    assign ForwardAE = sel_e[0];
    assign ForwardBE = sel_e[1];

    // Saturating counters; a cycle with both stall causes is charged to load-use only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lw_cnt <= '0;
            br_cnt <= '0;
        end else begin
            if (lwstall && (lw_cnt != CNT_MAX)) begin
                lw_cnt <= lw_cnt + CNT_ONE;
            end
            if (brstall && !lwstall && (br_cnt != CNT_MAX)) begin
                br_cnt <= br_cnt + CNT_ONE;
            end
        end
    end

    assign lw_stall_cnt = lw_cnt;
    assign br_stall_cnt = br_cnt;

endmodule

`default_nettype wire
